instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch front end. It reads one 8-bit instruction word at the
//   current PC from instruction memory, holds it for the decoder until the
//   decoder accepts it, then advances the PC. The PC advances either
//   sequentially (pc+1, wrapping at 256) or by an in-page jump that replaces
//   the low five PC bits with instr[4:0].
//
//   Three-state FSM:
//     IDLE  : nothing outstanding; leaves on the first edge with run=1.
//     FETCH : imem_req=1, imem_addr=pc held until imem_ack; run is ignored.
//     HOLD  : instr_valid=1 until accept (decode_ready=1); then FETCH or IDLE.
//
// Optional feature (compile-time macro IFU_FETCH_COUNT_EN):
//   When defined, adds a 16-bit saturating count of accepted instructions on
//   output fetch_count. When undefined, the port and counter are absent.
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-high reset
//   run          in   1  fetch enable
//   imem_req     out  1  instruction-memory read request
//   imem_addr    out  8  read address (always equals pc)
//   imem_ack     in   1  read data valid; only honoured in FETCH
//   imem_rdata   in   8  instruction word from memory
//   instr        out  8  held instruction
//   op_code      out  3  instr[7:5]
//   instr_valid  out  1  instr/op_code valid
//   decode_ready in   1  downstream accepts instr
//   jump         in   1  jump decode for the held instruction
//   pc           out  8  address of the held instruction
//   fetch_count  out 16  accepted-instruction count (IFU_FETCH_COUNT_EN only)
// -----------------------------------------------------------------------------
module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    output logic [7:0]  instr,
    output logic [2:0]  op_code,
    output logic        instr_valid,
    input  logic        decode_ready,
    input  logic        jump,
    output logic [7:0]  pc
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  pc_reg;
    logic [7:0]  instr_reg;
    logic        req_reg;
    logic        valid_reg;

    logic        accept;
    logic [7:0]  pc_next;

    // The held instruction is consumed when it is valid and the decoder is
    // ready on the same edge. valid_reg is only ever set while in HOLD.
    assign accept = valid_reg && decode_ready;

    // Jump target stays within the current 32-byte page of the PC.
    // A target equal to the current pc simply re-fetches the same address.
    always_comb begin
        pc_next = pc_reg + 8'd1;
        if (jump) begin
            pc_next = {pc_reg[7:5], instr_reg[4:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= 8'h00;
            instr_reg <= 8'h00;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) begin
                        state_reg <= FETCH;
                        req_reg   <= 1'b1;
                    end
                end
                FETCH: begin
                    // run is deliberately not looked at here: a request that
                    // has been issued always runs to completion.
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        valid_reg <= 1'b1;
                        req_reg   <= 1'b0;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc_reg    <= pc_next;
                        valid_reg <= 1'b0;
                        if (run) begin
                            state_reg <= FETCH;
                            req_reg   <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] count_reg;

    // Saturating count of accepted instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 16'h0000;
        end else if (accept && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign fetch_count = count_reg;
`endif

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign op_code     = instr_reg[7:5];
    assign instr_valid = valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A behavioural model tracks what
// the fetch unit must present (request outstanding, instruction held, pc,
// instruction word, accepted count) and a compare process checks every DUT
// output against it on each falling clock edge. Directed scenarios add
// hand-computed literal expectations. Inputs change only on falling edges.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic [7:0]  instr;
    logic [2:0]  op_code;
    logic        instr_valid;
    logic        decode_ready;
    logic        jump;
    logic [7:0]  pc;
`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .op_code      (op_code),
        .instr_valid  (instr_valid),
        .decode_ready (decode_ready),
        .jump         (jump),
        .pc           (pc)
`ifdef IFU_FETCH_COUNT_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    logic        m_req;     // a memory read is outstanding
    logic        m_have;    // an instruction is held for the decoder
    logic [7:0]  m_pc;
    logic [7:0]  m_instr;
    int          m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req   <= 1'b0;
            m_have  <= 1'b0;
            m_pc    <= 8'h00;
            m_instr <= 8'h00;
            m_count <= 0;
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_have  <= 1'b1;
                m_req   <= 1'b0;
            end
        end else if (m_have) begin
            if (decode_ready) begin
                if (jump)
                    m_pc <= (m_pc & 8'hE0) | (m_instr & 8'h1F);
                else
                    m_pc <= 8'((int'(m_pc) + 1) % 256);
                m_have  <= 1'b0;
                m_req   <= run;
                m_count <= (m_count < 65535) ? m_count + 1 : 65535;
            end
        end else if (run) begin
            m_req <= 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------- per-cycle compare
    always @(negedge clk) begin
        cmp("imem_req",    16'(imem_req),    16'(m_req));
        cmp("imem_addr",   16'(imem_addr),   16'(m_pc));
        cmp("pc",          16'(pc),          16'(m_pc));
        cmp("instr",       16'(instr),       16'(m_instr));
        cmp("op_code",     16'(op_code),     16'(m_instr >> 5));
        cmp("instr_valid", 16'(instr_valid), 16'(m_have));
`ifdef IFU_FETCH_COUNT_EN
        cmp("fetch_count", fetch_count,      16'(m_count));
`endif
        $display("cyc t=%0t req=%b addr=%h valid=%b instr=%h op=%0d pc=%h",
                 $time, imem_req, imem_addr, instr_valid, instr, op_code, pc);
    end

    // ------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk);
    endtask

    // Stream sequential fetches until a request for 'target' is outstanding.
    task automatic run_to_fetch(input logic [7:0] target);
        int n;
        n = 0;
        run = 1'b1; imem_ack = 1'b1; decode_ready = 1'b1; jump = 1'b0; imem_rdata = 8'h00;
        while (!(m_req && m_pc == target) && n < 1000) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 1000) begin
            miscompares++;
            $display("FAIL run_to_fetch timeout: got pc %h, expected fetch of %h", m_pc, target);
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00;
        decode_ready = 1'b0; jump = 1'b0;

        // Reset state
        tick();
        cmp("rst_pc",    16'(pc), 16'h00);
        cmp("rst_addr",  16'(imem_addr), 16'h00);
        cmp("rst_instr", 16'(instr), 16'h00);
        cmp("rst_op",    16'(op_code), 16'h0);
        cmp("rst_valid", 16'(instr_valid), 16'h0);
        cmp("rst_req",   16'(imem_req), 16'h0);
        rst = 1'b0;

        // Immediate ack, back-to-back fetches of 8'h4A
        run = 1'b1; imem_ack = 1'b1; imem_rdata = 8'h4A; decode_ready = 1'b1; jump = 1'b0;
        tick();
        cmp("s1_req0",   16'(imem_req), 16'h1);
        cmp("s1_addr0",  16'(imem_addr), 16'h00);
        tick();
        cmp("s1_valid0", 16'(instr_valid), 16'h1);
        cmp("s1_instr",  16'(instr), 16'h4A);
        cmp("s1_op",     16'(op_code), 16'h2);
        cmp("s1_pc0",    16'(pc), 16'h00);
        tick();
        cmp("s1_valid1", 16'(instr_valid), 16'h0);
        cmp("s1_addr1",  16'(imem_addr), 16'h01);
        tick();
        cmp("s1_valid2", 16'(instr_valid), 16'h1);
        cmp("s1_pc1",    16'(pc), 16'h01);
        tick();
        cmp("s1_addr2",  16'(imem_addr), 16'h02);

        // Ack delayed three cycles at pc 8'h05
        run_to_fetch(8'h05);
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            cmp("s2_req",   16'(imem_req), 16'h1);
            cmp("s2_addr",  16'(imem_addr), 16'h05);
            cmp("s2_valid", 16'(instr_valid), 16'h0);
        end
        imem_ack = 1'b1; imem_rdata = 8'h2C;
        tick();
        cmp("s2_valid_hi", 16'(instr_valid), 16'h1);
        cmp("s2_instr",    16'(instr), 16'h2C);

        // In-page jump: instr 8'hB3 at pc 8'h47 -> 8'h53
        run_to_fetch(8'h47);
        imem_rdata = 8'hB3;
        tick();
        cmp("s3_instr", 16'(instr), 16'hB3);
        cmp("s3_op",    16'(op_code), 16'h5);
        cmp("s3_pc",    16'(pc), 16'h47);
        jump = 1'b1;
        tick();
        cmp("s3_addr",  16'(imem_addr), 16'h53);
        cmp("s3_req",   16'(imem_req), 16'h1);

        // Decoder stall for 5 cycles with spurious acks and changing rdata
        jump = 1'b0; decode_ready = 1'b0; imem_rdata = 8'hE7;
        tick();
        imem_rdata = 8'h11;
        for (int i = 0; i < 5; i++) begin
            cmp("s4_instr", 16'(instr), 16'hE7);
            cmp("s4_op",    16'(op_code), 16'h7);
            cmp("s4_pc",    16'(pc), 16'h53);
            cmp("s4_req",   16'(imem_req), 16'h0);
            cmp("s4_valid", 16'(instr_valid), 16'h1);
            tick();
        end
        decode_ready = 1'b1;
        tick();
        cmp("s4_addr", 16'(imem_addr), 16'h54);

        // PC wrap from 8'hFF
        run_to_fetch(8'hFF);
        tick();
        cmp("s5_pc", 16'(pc), 16'hFF);
        tick();
        cmp("s5_addr", 16'(imem_addr), 16'h00);

        // Reset while a request at 8'h10 is outstanding; ack arrives late
        run_to_fetch(8'h10);
        cmp("s6_req_pre", 16'(imem_req), 16'h1);
        imem_ack = 1'b0; run = 1'b0; imem_rdata = 8'h99;
        #2 rst = 1'b1;
        tick();
        cmp("s6_pc_rst",  16'(pc), 16'h00);
        cmp("s6_req_rst", 16'(imem_req), 16'h0);
        imem_ack = 1'b1;
        #2 rst = 1'b0;
        tick();
        cmp("s6_pc",    16'(pc), 16'h00);
        cmp("s6_valid", 16'(instr_valid), 16'h0);
        cmp("s6_instr", 16'(instr), 16'h00);
        cmp("s6_req",   16'(imem_req), 16'h0);
`ifdef IFU_FETCH_COUNT_EN
        cmp("s6_count", fetch_count, 16'h0000);
`endif
        imem_ack = 1'b0; run = 1'b1;
        tick();
        cmp("s6_refetch", 16'(imem_req), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
